// File: rtl/pipe_ctrl_pkg.sv
// Shared fetch-control types and helpers: FSM state encoding, PC
// increment and redirect-target alignment.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_PEND = 2'd2
  } fetch_state_t;

  localparam int PC_STEP = 4;

  // Keep only the low pc_w bits of the branch target and force word alignment.
  // The shift wraps to zero when pc_w is 32, so the mask becomes all ones.
  function automatic logic [31:0] align_tgt(input logic [31:0] br_pc, input int pc_w);
    logic [31:0] width_mask;
    width_mask = (32'h1 << pc_w) - 32'h1;
    return br_pc & width_mask & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: sequences instruction fetches over valid/ready, applies
// EX-stage redirects, honours load-use stalls and raises wrong-path flushes.
module fetch_redirect_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            imem_ready,
  output logic [PC_W-1:0] PC,
  output logic            fetch_valid,
  output logic            Flush_IFID,
  output logic            Flush_IDEX,
  output logic            Misalign
);

  fetch_state_t    state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pend_reg;
  logic            fetch_valid_reg;
  logic            misalign_reg;

  logic [PC_W-1:0] tgt;
  logic            accept_redirect;

  assign tgt             = PC_W'(align_tgt(BrPC, PC_W));
  // A redirect is only meaningful once fetching has started.
  assign accept_redirect = PcSel && (state_reg != FS_BOOT);

  // FSM, next-PC selection and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= FS_BOOT;
      pc_reg          <= RESET_PC;
      pend_reg        <= '0;
      fetch_valid_reg <= 1'b0;
      misalign_reg    <= 1'b0;
    end else begin
      misalign_reg <= accept_redirect && (BrPC[1:0] != 2'b00);
      case (state_reg)
        FS_BOOT: begin
          state_reg       <= FS_RUN;
          fetch_valid_reg <= 1'b1;
        end
        FS_RUN: begin
          if (PcSel) begin
            // Redirect beats stall: the stalled instruction is wrong-path.
            if (imem_ready) begin
              pc_reg <= tgt;
            end else begin
              // Address must stay stable while the request is outstanding.
              pend_reg  <= tgt;
              state_reg <= FS_PEND;
            end
          end else if (!Stall && imem_ready) begin
            pc_reg <= pc_reg + PC_W'(PC_STEP);
          end
        end
        FS_PEND: begin
          if (PcSel) begin
            // A newer redirect supersedes the parked one.
            if (imem_ready) begin
              pc_reg    <= tgt;
              state_reg <= FS_RUN;
            end else begin
              pend_reg <= tgt;
            end
          end else if (imem_ready) begin
            pc_reg    <= pend_reg;
            state_reg <= FS_RUN;
          end
        end
        default: begin
          state_reg       <= FS_BOOT;
          fetch_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Flush strobes are the only combinational outputs; silent during reset.
  always_comb begin
    Flush_IFID = 1'b0;
    Flush_IDEX = 1'b0;
    if (reset) begin
      case (state_reg)
        FS_RUN: begin
          Flush_IFID = PcSel;
          Flush_IDEX = PcSel;
        end
        FS_PEND: begin
          // The stale fetch completing here must land in IF/ID as a bubble.
          Flush_IFID = PcSel || imem_ready;
          Flush_IDEX = PcSel;
        end
        default: begin
          Flush_IFID = 1'b0;
          Flush_IDEX = 1'b0;
        end
      endcase
    end
  end

  assign PC          = pc_reg;
  assign fetch_valid = fetch_valid_reg;
  assign Misalign    = misalign_reg;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: each step pushes its expected
// flushes (same cycle) and registered outputs (after the edge) to a queue.
module tb_fetch_redirect_ctrl;

  localparam int PC_W = 9;

  logic            clk;
  logic            reset;
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            imem_ready;
  logic [PC_W-1:0] PC;
  logic            fetch_valid;
  logic            Flush_IFID;
  logic            Flush_IDEX;
  logic            Misalign;

  typedef struct {
    string           tag;
    logic            ifid;
    logic            idex;
    logic [PC_W-1:0] pc;
    logic            fv;
    logic            mis;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  fetch_redirect_ctrl #(.PC_W(PC_W), .RESET_PC(9'h000)) dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .PcSel      (PcSel),
    .BrPC       (BrPC),
    .imem_ready (imem_ready),
    .PC         (PC),
    .fetch_valid(fetch_valid),
    .Flush_IFID (Flush_IFID),
    .Flush_IDEX (Flush_IDEX),
    .Misalign   (Misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check flushes mid-cycle, check registers after the edge.
  task automatic cyc(input string tag, input logic r, input logic st, input logic ps,
                     input logic [31:0] br, input logic rd,
                     input logic e_ifid, input logic e_idex,
                     input logic [PC_W-1:0] e_pc, input logic e_fv, input logic e_mis);
    exp_t e;
    e.tag = tag; e.ifid = e_ifid; e.idex = e_idex; e.pc = e_pc; e.fv = e_fv; e.mis = e_mis;
    reset = r; Stall = st; PcSel = ps; BrPC = br; imem_ready = rd;
    sb.push_back(e);
    @(negedge clk);
    e = sb[0];
    chk(e.tag, "Flush_IFID", 32'(Flush_IFID), 32'(e.ifid));
    chk(e.tag, "Flush_IDEX", 32'(Flush_IDEX), 32'(e.idex));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "PC", 32'(PC), 32'(e.pc));
    chk(e.tag, "fetch_valid", 32'(fetch_valid), 32'(e.fv));
    chk(e.tag, "Misalign", 32'(Misalign), 32'(e.mis));
    $display("step %-10s PC=%03h fv=%0b ifid=%0b idex=%0b mis=%0b", tag, PC, fetch_valid,
             e.ifid, e.idex, Misalign);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0; Stall = 1'b0; PcSel = 1'b0; BrPC = '0; imem_ready = 1'b1;
    @(posedge clk);
    #1;

    //   tag          rst st ps br          rdy ifid idex pc      fv mis
    cyc("reset",      0, 0, 0, 32'h0,     1,  0,   0,   9'h000, 0, 0);
    // Boot cycle, then sequential fetch
    cyc("boot",       1, 0, 0, 32'h0,     1,  0,   0,   9'h000, 1, 0);
    cyc("seq4",       1, 0, 0, 32'h0,     1,  0,   0,   9'h004, 1, 0);
    cyc("seq8",       1, 0, 0, 32'h0,     1,  0,   0,   9'h008, 1, 0);
    cyc("seqC",       1, 0, 0, 32'h0,     1,  0,   0,   9'h00C, 1, 0);
    cyc("seq10",      1, 0, 0, 32'h0,     1,  0,   0,   9'h010, 1, 0);
    // Redirect with stall asserted: redirect wins
    cyc("br40",       1, 1, 1, 32'h40,    1,  1,   1,   9'h040, 1, 0);
    cyc("br20",       1, 0, 1, 32'h20,    1,  1,   1,   9'h020, 1, 0);
    // Redirect while memory not ready: park target, hold PC
    cyc("pend_in",    1, 0, 1, 32'h80,    0,  1,   1,   9'h020, 1, 0);
    cyc("pend_w1",    1, 0, 0, 32'h0,     0,  0,   0,   9'h020, 1, 0);
    cyc("pend_rdy",   1, 1, 0, 32'h0,     1,  1,   0,   9'h080, 1, 0);
    cyc("post_pend",  1, 0, 0, 32'h0,     1,  0,   0,   9'h084, 1, 0);
    // Truncated, misaligned target
    cyc("brA36",      1, 0, 1, 32'hA36,   1,  1,   1,   9'h034, 1, 1);
    cyc("mis_drop",   1, 0, 0, 32'h0,     1,  0,   0,   9'h038, 1, 0);
    // Wrap at top of the PC space
    cyc("br1F8",      1, 0, 1, 32'h1F8,   1,  1,   1,   9'h1F8, 1, 0);
    cyc("seq1FC",     1, 0, 0, 32'h0,     1,  0,   0,   9'h1FC, 1, 0);
    cyc("wrap",       1, 0, 0, 32'h0,     1,  0,   0,   9'h000, 1, 0);
    cyc("stall1",     1, 1, 0, 32'h0,     1,  0,   0,   9'h000, 1, 0);
    cyc("stall2",     1, 1, 0, 32'h0,     1,  0,   0,   9'h000, 1, 0);
    cyc("stall3",     1, 1, 0, 32'h0,     1,  0,   0,   9'h000, 1, 0);
    cyc("notready",   1, 0, 0, 32'h0,     0,  0,   0,   9'h000, 1, 0);
    // Redirects arriving while already pending overwrite the parked target
    cyc("pend_mis",   1, 0, 1, 32'h103,   0,  1,   1,   9'h000, 1, 1);
    cyc("pend_ovr",   1, 0, 1, 32'h80,    0,  1,   1,   9'h000, 1, 0);
    // Reset while pending discards the parked target without flushing
    cyc("pend_rst",   0, 0, 0, 32'h0,     1,  0,   0,   9'h000, 0, 0);
    cyc("reboot",     1, 0, 0, 32'h0,     1,  0,   0,   9'h000, 1, 0);
    cyc("rb_seq4",    1, 0, 0, 32'h0,     1,  0,   0,   9'h004, 1, 0);
    cyc("rb_seq8",    1, 0, 0, 32'h0,     1,  0,   0,   9'h008, 1, 0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Owns the fetch PC and consumes the redirect (PcSel, BrPC) produced by the EX-stage branch unit. It sequences fetch requests to instruction memory over a valid/ready handshake and handles load-use stalls. It raises the IF/ID and ID/EX flush strobes that squash wrong-path instructions. It sits between the hazard unit, the EX-stage branch logic and the IF stage.

Parameters:
PC_W, 9, fetch PC width in bits (byte address); arithmetic wraps modulo 2^PC_W
RESET_PC, 0, PC value loaded on reset; must be a multiple of 4

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset (0 = reset asserted)
Stall  in  1  hazard-unit stall request; hold PC when no redirect is present
PcSel  in  1  redirect request from EX-stage branch logic
BrPC  in  32  redirect target; valid only when PcSel=1
imem_ready  in  1  instruction memory accepts the current fetch
PC  out  PC_W  current fetch address, registered
fetch_valid  out  1  fetch request valid, registered
Flush_IFID  out  1  IF/ID pipeline register loads a bubble this cycle
Flush_IDEX  out  1  ID/EX pipeline register loads a bubble this cycle
Misalign  out  1  one-cycle pulse when an accepted redirect target has BrPC[1:0]≠0

Behaviour:
- Reset (reset=0 at edge): PC=RESET_PC, fetch_valid=0, state=FS_BOOT, pending target cleared, Misalign=0. Flush_IFID and Flush_IDEX are forced 0 while reset=0.
- Target formation: tgt = {BrPC[PC_W-1:2], 2'b00}. BrPC bits above PC_W-1 are ignored. Misalign is registered, so it is high in the cycle after a redirect is captured with BrPC[1:0]≠0.
- FS_BOOT: fetch_valid=0 and PcSel is ignored. Next edge goes to FS_RUN with fetch_valid=1 and PC unchanged.
- FS_RUN, priority order at each edge:
  1. PcSel=1 and imem_ready=1:
     - Flush_IFID=1 and Flush_IDEX=1 combinationally in the same cycle.
     - PC<=tgt. Stay in FS_RUN.
     - Stall is ignored, because the stalled instruction is wrong-path.
  2. PcSel=1 and imem_ready=0:
     - Flush_IFID=1 and Flush_IDEX=1 in that cycle.
     - pend<=tgt and PC is held, because valid/ready requires a stable address while valid and not ready.
     - Go to FS_PEND.
  3. Stall=1 or imem_ready=0: hold PC.
  4. Otherwise: PC<=PC+4, wrapping modulo 2^PC_W. With PC_W=9, 0x1FC+4 gives 0x000.
- FS_PEND: fetch_valid=1 and PC is held until imem_ready=1.
  - In the cycle imem_ready=1, Flush_IFID=1 so the stale fetch lands as a bubble. Flush_IDEX=0.
  - At that edge PC<=pend and the state returns to FS_RUN.
  - Stall is ignored in FS_PEND.
  - A new PcSel in FS_PEND overwrites pend with the new tgt and raises Flush_IDEX=1 and Flush_IFID=1 that cycle. Misalign is evaluated on the new target.
- fetch_valid is 1 in every state except FS_BOOT. One fetch is accepted per cycle with fetch_valid&&imem_ready.
- Reset in FS_PEND discards pend with no flush, and the next state is FS_BOOT.
- There is no combinational path from PcSel or BrPC to PC. The flush outputs are the only combinational outputs.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - enum fetch_state_t {FS_BOOT, FS_RUN, FS_PEND}
  - localparam PC_STEP=4
  - function align_tgt(BrPC, PC_W)
- No sub-module. The next-PC mux and the FSM stay in one always_ff block and one always_comb block.

Test Plan:
1. Reset, then release with imem_ready=1, Stall=0 → cycle 1: PC=0x000, fetch_valid=0. Then fetch_valid=1 and PC=0x000, 0x004, 0x008 on successive cycles.
2. PC=0x010, PcSel=1, BrPC=0x00000040, imem_ready=1, Stall=1 → same cycle Flush_IFID=1, Flush_IDEX=1. Next cycle PC=0x040, Misalign=0.
3. PC=0x020, imem_ready=0, PcSel=1, BrPC=0x80; hold imem_ready=0 for 2 cycles then 1 → PC stays 0x020 through the wait. Flush_IFID=1 in the ready cycle. PC=0x080 the cycle after.
4. PcSel=1, BrPC=0x0000_0A36 with PC_W=9 → PC=0x034 and Misalign pulses for exactly one cycle.
5. Free-run from PC=0x1F8 with no stalls → 0x1FC then 0x000. Then Stall=1 for 3 cycles → PC frozen at 0x000 with both flushes 0.
6. In FS_PEND with pend=0x080, assert reset=0 for one cycle → PC=RESET_PC, fetch_valid=0, no flush. After release, PC 0x080 is never loaded.
